// File: rtl/cnn_pkg.sv
// cnn_pkg: shared defaults and FSM state encoding for the window generator
package cnn_pkg;
  localparam int DEF_WIDTH = 10;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
endpackage

// File: rtl/line_delay.sv
// line_delay: DEPTH-entry shift register advanced on en; dout is the entry pushed DEPTH enables ago
module line_delay #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 32
) (
  input  logic                    clk,
  input  logic                    en,
  input  logic signed [WIDTH-1:0] din,
  output logic signed [WIDTH-1:0] dout
);
  logic signed [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (en) begin
      mem[0] <= din;
      for (int k = 1; k < DEPTH; k++) mem[k] <= mem[k-1];
    end
  assign dout = mem[DEPTH-1];
endmodule

// File: rtl/window_gen_3x3.sv
// window_gen_3x3: raster pixel stream (in_valid/in_sof/in_data) to registered 3x3 window (win_j_i, out_valid, frame_done)
module window_gen_3x3 import cnn_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int IMG_W = 32,
  parameter int IMG_H = 32
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    in_valid,
  input  logic                    in_sof,
  input  logic signed [WIDTH-1:0] in_data,
  output logic signed [WIDTH-1:0] win_0_0,
  output logic signed [WIDTH-1:0] win_1_0,
  output logic signed [WIDTH-1:0] win_2_0,
  output logic signed [WIDTH-1:0] win_0_1,
  output logic signed [WIDTH-1:0] win_1_1,
  output logic signed [WIDTH-1:0] win_2_1,
  output logic signed [WIDTH-1:0] win_0_2,
  output logic signed [WIDTH-1:0] win_1_2,
  output logic signed [WIDTH-1:0] win_2_2,
  output logic                    out_valid,
  output logic                    frame_done
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] C_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] R_LAST = RW'(IMG_H - 1);
  logic [1:0] state;
  logic [CW-1:0] col, cur_c;
  logic [RW-1:0] row, cur_r;
  logic accept, last_c, eof;
  logic signed [WIDTH-1:0] up1, up2;
  always_comb begin
    accept = in_valid && (in_sof || state != ST_IDLE);
    cur_c = in_sof ? '0 : col;
    cur_r = in_sof ? '0 : row;
    last_c = cur_c == C_LAST;
    eof = last_c && cur_r == R_LAST;
  end
  line_delay #(.WIDTH(WIDTH), .DEPTH(IMG_W)) u_ld1 (.clk(clk), .en(accept), .din(in_data), .dout(up1));
  line_delay #(.WIDTH(WIDTH), .DEPTH(IMG_W)) u_ld2 (.clk(clk), .en(accept), .din(up1), .dout(up2));
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state <= ST_IDLE;
      col <= '0;
      row <= '0;
      out_valid <= 1'b0;
      frame_done <= 1'b0;
      {win_0_0, win_1_0, win_2_0, win_0_1, win_1_1, win_2_1, win_0_2, win_1_2, win_2_2} <= '0;
    end else begin
      out_valid <= accept && cur_r >= RW'(2) && cur_c >= CW'(2);
      frame_done <= accept && eof;
      if (accept) begin
        state <= eof ? ST_IDLE : (last_c && cur_r == RW'(1)) ? ST_RUN : in_sof ? ST_FILL : state;
        col <= last_c ? '0 : cur_c + CW'(1);
        row <= eof ? '0 : last_c ? cur_r + RW'(1) : cur_r;
        win_0_0 <= win_1_0;
        win_1_0 <= win_2_0;
        win_2_0 <= up2;
        win_0_1 <= win_1_1;
        win_1_1 <= win_2_1;
        win_2_1 <= up1;
        win_0_2 <= win_1_2;
        win_1_2 <= win_2_2;
        win_2_2 <= in_data;
      end
    end
endmodule

// File: tb/tb_window_gen_3x3.sv
// tb_window_gen_3x3: image-array model with per-cycle compare plus literal frame expectations
module tb_window_gen_3x3;
  localparam int W = 5;
  localparam int H = 4;
  logic clk = 0;
  logic resetn = 0;
  logic in_valid = 0;
  logic in_sof = 0;
  logic signed [9:0] in_data = '0;
  logic signed [9:0] win_0_0, win_1_0, win_2_0, win_0_1, win_1_1, win_2_1, win_0_2, win_1_2, win_2_2;
  logic out_valid, frame_done;
  logic signed [9:0] w [3][3];
  int checks = 0;
  int errors = 0;
  int img [H][W];
  int mr, mc;
  bit act;
  bit nxt_v, nxt_fd, exp_v, exp_fd;
  int nxt_w [3][3];
  int exp_w [3][3];
  bit run_chk = 0;
  int nwin, nfd, f00, f10, f11, f22, fdw22;
  window_gen_3x3 #(.WIDTH(10), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
    .win_0_0(win_0_0), .win_1_0(win_1_0), .win_2_0(win_2_0),
    .win_0_1(win_0_1), .win_1_1(win_1_1), .win_2_1(win_2_1),
    .win_0_2(win_0_2), .win_1_2(win_1_2), .win_2_2(win_2_2),
    .out_valid(out_valid), .frame_done(frame_done)
  );
  assign w[0][0] = win_0_0;
  assign w[1][0] = win_1_0;
  assign w[2][0] = win_2_0;
  assign w[0][1] = win_0_1;
  assign w[1][1] = win_1_1;
  assign w[2][1] = win_2_1;
  assign w[0][2] = win_0_2;
  assign w[1][2] = win_1_2;
  assign w[2][2] = win_2_2;
  always #5 clk = ~clk;
  task automatic chk(string name, int act_v, int exp_val);
    checks++;
    if (act_v != exp_val) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act_v, exp_val, $time);
    end
  endtask
  task automatic model(bit v, bit s, int d);
    nxt_v = 0;
    nxt_fd = 0;
    if (v && s) begin
      act = 1;
      mr = 0;
      mc = 0;
    end
    if (v && act) begin
      img[mr][mc] = d;
      if (mr >= 2 && mc >= 2) begin
        nxt_v = 1;
        nxt_fd = (mr == H - 1 && mc == W - 1);
        for (int j = 0; j < 3; j++)
          for (int i = 0; i < 3; i++) nxt_w[j][i] = img[mr-2+i][mc-2+j];
      end
      mc++;
      if (mc == W) begin
        mc = 0;
        mr++;
        if (mr == H) act = 0;
      end
    end
  endtask
  task automatic step(bit v, bit s, int d);
    in_valid = v;
    in_sof = s;
    in_data = 10'(d);
    model(v, s, d);
    @(posedge clk);
    #1;
    exp_v = nxt_v;
    exp_fd = nxt_fd;
    exp_w = nxt_w;
  endtask
  task automatic frame(int base, bit gaps, bit alt, int npix);
    for (int k = 0; k < npix; k++) begin
      step(1, k == 0, alt ? ((k % 2) ? 511 : -512) : base + k);
      if (gaps) step(0, 0, 333);
    end
    step(0, 0, 0);
    step(0, 0, 0);
  endtask
  task automatic clear_cap();
    nwin = 0;
    nfd = 0;
    f00 = -1000;
    f10 = -1000;
    f11 = -1000;
    f22 = -1000;
    fdw22 = -1000;
  endtask
  task automatic expect_frame(string tag, int e00, int e10, int e11, int e22, int efd);
    chk({tag, " window count"}, nwin, 6);
    chk({tag, " frame_done count"}, nfd, 1);
    chk({tag, " first win_0_0"}, f00, e00);
    chk({tag, " first win_1_0"}, f10, e10);
    chk({tag, " first win_1_1"}, f11, e11);
    chk({tag, " first win_2_2"}, f22, e22);
    chk({tag, " done win_2_2"}, fdw22, efd);
    clear_cap();
  endtask
  task automatic outputs_zero(string tag);
    chk({tag, " out_valid"}, int'(out_valid), 0);
    chk({tag, " frame_done"}, int'(frame_done), 0);
    for (int j = 0; j < 3; j++)
      for (int i = 0; i < 3; i++) chk($sformatf("%s win_%0d_%0d", tag, j, i), int'(w[j][i]), 0);
  endtask
  always @(negedge clk)
    if (resetn && run_chk) begin
      chk("out_valid", int'(out_valid), int'(exp_v));
      chk("frame_done", int'(frame_done), int'(exp_fd));
      if (exp_v)
        for (int j = 0; j < 3; j++)
          for (int i = 0; i < 3; i++) chk($sformatf("win_%0d_%0d", j, i), int'(w[j][i]), exp_w[j][i]);
      if (out_valid) begin
        nwin++;
        if (nwin == 1) begin
          f00 = int'(win_0_0);
          f10 = int'(win_1_0);
          f11 = int'(win_1_1);
          f22 = int'(win_2_2);
        end
        if (frame_done) begin
          nfd++;
          fdw22 = int'(win_2_2);
        end
      end
    end
  initial begin
    clear_cap();
    repeat (3) @(posedge clk);
    #1;
    outputs_zero("reset");
    resetn = 1;
    run_chk = 1;
    step(0, 0, 0);
    frame(0, 0, 0, W * H);
    expect_frame("basic", 0, 1, 6, 12, 19);
    frame(0, 1, 0, W * H);
    expect_frame("gaps", 0, 1, 6, 12, 19);
    for (int k = 0; k < 7; k++) step(1, 0, 77);
    step(0, 0, 0);
    chk("idle no windows", nwin, 0);
    frame(0, 0, 0, W * H);
    expect_frame("after idle", 0, 1, 6, 12, 19);
    frame(0, 0, 0, 13);
    chk("pre-abort windows", nwin, 1);
    clear_cap();
    frame(100, 0, 0, W * H);
    expect_frame("abort", 100, 101, 106, 112, 119);
    for (int k = 0; k < 14; k++) step(1, k == 0, k);
    resetn = 0;
    act = 0;
    exp_v = 0;
    exp_fd = 0;
    #1;
    outputs_zero("mid reset");
    @(posedge clk);
    #1;
    resetn = 1;
    clear_cap();
    for (int k = 0; k < 6; k++) step(1, 0, 55);
    chk("post reset no windows", nwin, 0);
    frame(0, 0, 0, W * H);
    expect_frame("post reset", 0, 1, 6, 12, 19);
    frame(0, 0, 1, W * H);
    expect_frame("extremes", -512, 511, -512, -512, 511);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/window_gen_3x3.md
WINDOW_GEN_3X3 -- requirements
Module: window_gen_3x3

Interface
REQ-001 SHALL have parameter WIDTH, default 10, pixel width in bits (signed two's complement).
REQ-002 SHALL have parameter IMG_W, default 32, pixels per row (legal range 3..1024).
REQ-003 SHALL have parameter IMG_H, default 32, rows per frame (legal range 3..1024).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port in_valid, input, 1 bit: in_data is accepted this cycle.
REQ-007 SHALL have port in_sof, input, 1 bit: start of frame; qualified by in_valid.
REQ-008 SHALL have port in_data, input, signed WIDTH bits: raster-order pixel.
REQ-009 SHALL have ports win_j_i (j = column 0..2, i = row 0..2), output, signed WIDTH bits, registered: 3x3 window; win_0_0 is top-left (oldest), win_2_2 is bottom-right (newest).
REQ-010 SHALL have port out_valid, output, 1 bit: all nine win_j_i hold a complete in-frame window.
REQ-011 SHALL have port frame_done, output, 1 bit: one-cycle pulse with the last window of a frame.

Function
REQ-012 SHALL implement FSM states IDLE, FILL and RUN; the reset state SHALL be IDLE.
REQ-013 IDLE: SHALL drop every pixel not marked in_sof; in_valid&in_sof SHALL take the pixel as (row 0, col 0) and go to FILL.
REQ-014 FILL -> RUN SHALL occur on the accepted pixel at (row 1, col IMG_W-1).
REQ-015 RUN -> IDLE SHALL occur on the accepted pixel at (row IMG_H-1, col IMG_W-1).
REQ-016 Column counter SHALL advance only on accepted pixels and wrap IMG_W-1 -> 0, incrementing the row counter.
REQ-017 Two line delays of IMG_W entries SHALL shift only on accepted pixels, providing the pixels one row and two rows above.
REQ-018 On an accepted pixel, each window row SHALL shift left (col 0 <- col 1 <- col 2), with col 2 loaded by row 0 = 2-rows-above, row 1 = 1-row-above, row 2 = in_data.
REQ-019 out_valid SHALL be 1 in the cycle after an accepted pixel with row >= 2 and col >= 2, and 0 otherwise, including during in_valid gaps.
REQ-020 Latency SHALL be 1 cycle from the accepted pixel to the window holding it as win_2_2.
REQ-021 A frame SHALL yield exactly (IMG_W-2)*(IMG_H-2) out_valid pulses; no padding windows.
REQ-022 frame_done SHALL coincide with the out_valid for pixel (IMG_H-1, IMG_W-1).
REQ-023 in_sof&in_valid in FILL or RUN SHALL abort the frame, restart at (0,0) in FILL, and emit no window mixing old and new frames.
REQ-024 in_sof without in_valid SHALL be ignored.
REQ-025 win_j_i SHALL hold their values when no pixel is accepted.
REQ-026 Data SHALL pass through bit-exact; no arithmetic, clipping or sign change.

Reset
REQ-027 resetn low SHALL asynchronously clear the FSM to IDLE, counters to 0, out_valid and frame_done to 0, and all win_j_i to 0.
REQ-028 Line-delay contents need not be cleared; REQ-019 SHALL keep stale data from ever being flagged valid.
REQ-029 Reset asserted mid-frame SHALL discard the frame; the next frame SHALL start only on in_sof.

Structure
REQ-030 The shared package cnn_pkg SHALL hold the default WIDTH and the FSM state encoding.
REQ-031 The line delay SHALL be one sub-module, line_delay (parameters WIDTH, DEPTH; shift on enable), instantiated twice.

Verification
REQ-032 IMG_W=5, IMG_H=4, pixel = 5*row+col, continuous in_valid -> the first out_valid follows pixel 12 with win_0_0=0, win_1_1=6, win_2_2=12; 6 windows total; frame_done on the window with win_2_2=19.
REQ-033 Same frame with in_valid low on every other cycle -> identical window sequence; out_valid is never high during a gap.
REQ-034 Pixels sent in IDLE without in_sof -> no out_valid; a following in_sof frame behaves as in REQ-032.
REQ-035 in_sof re-asserted at pixel (2,3) -> no window from the aborted frame after it; the new frame's first window is its own (2,2).
REQ-036 resetn pulsed low after pixel 13 -> all outputs are 0 immediately; the next in_sof frame matches REQ-032.
REQ-037 Pixels alternating -512 and 511 -> windows carry the values bit-exact with sign preserved.
